uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Parametrised UART transmitter with configurable frame format, an integrated transmit FIFO and a valid/ready input handshake. It runs entirely in the system clock domain and derives bit timing from an internal divider, so no separate UART clock is needed. It sits between a byte-producing master (CPU bridge, DMA, debug logger) and the board-level TX pin.

## Interface
Parameters:
- DIV, 868, system clocks per UART bit; legal range ≥ 2 (868 gives 115200 baud from 100 MHz).
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  8  byte to send; only bits [DATA_BITS-1:0] are transmitted.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a byte; equals "FIFO not full".
- txd  out  1  serial output, registered, idles high.
- busy  out  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes stored in the FIFO.

## Operation
- Push: a byte is written when in_valid && in_ready at a clock edge. Pushes while full are not accepted, and in_data is ignored.
- Frame, LSB first: start bit (0), DATA_BITS data bits, optional parity bit, then STOP_BITS stop bits (1).
- Parity is computed over the transmitted DATA_BITS only:
  - Odd mode: the parity bit makes the total number of 1s, including the parity bit, odd.
  - Even mode: the parity bit makes that total even.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty. The head byte is popped into the shift register on this transition.
  - START -> DATA after DIV clocks.
  - DATA -> PARITY (PARITY≠0) or STOP after DATA_BITS bit periods.
  - PARITY -> STOP after one bit period.
  - STOP -> START if the FIFO is non-empty (back-to-back, no idle gap), otherwise STOP -> IDLE, after STOP_BITS bit periods.
- Bit counter is 3 bits wide. The divider counts 0..DIV-1, resets to 0 on every state entry from IDLE, and wraps with no drift.
- The FIFO is a circular buffer with read and write pointers one bit wider than the address. Full and empty are detected from the MSB and address comparison. Pointers wrap modulo 2·FIFO_DEPTH.
- Simultaneous push and pop in one cycle: both take effect and fifo_count is unchanged. in_ready reflects the count before the pop (no same-cycle pass-through when full).

## Timing
- Reset values (asynchronous, mid-frame included): txd=1, in_ready=1, busy=0, fifo_count=0, FSM=IDLE, FIFO emptied, divider=0. A frame in progress is abandoned and no partial frame resumes after reset release.
- Start latency: when a push is accepted at edge N into an empty FIFO while IDLE, fifo_count=1 after edge N. At edge N+1 the FSM enters START, txd=0 and fifo_count=0.
- Every bit lasts exactly DIV clocks.
- Frame length F = DIV·(1 + DATA_BITS + (PARITY≠0) + STOP_BITS) clocks.
- Back-to-back frames: the next start bit begins exactly F clocks after the previous start bit.
- busy rises at the edge of the first accepted push. It falls at the edge where the last stop bit ends with the FIFO empty, which is the same edge txd stays 1 and the FSM enters IDLE.
- in_ready deasserts at the edge fifo_count reaches FIFO_DEPTH. It reasserts at the edge of the next pop.
- in_data and in_valid changes while in_ready=0 have no effect.

## Test plan
- Basic frame: DIV=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; push 0xA5 -> txd = 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 clocks (44 clocks total). Start bit begins 1 cycle after acceptance. busy drops after 44 clocks.
- Odd parity with 7 data bits and 2 stop bits: DIV=4, DATA_BITS=7, PARITY=1, STOP_BITS=2; push 0x03 -> data 1,1,0,0,0,0,0, parity 1, stop 1,1 (frame 44 clocks). Bit 7 of in_data is ignored.
- FIFO fill and back-to-back: FIFO_DEPTH=4; push 5 bytes on consecutive cycles while IDLE ->
  - all 5 are accepted: the first is popped immediately, so fifo_count peaks at 4;
  - in_ready=0 while count=4;
  - frames are contiguous, with start bits spaced exactly F clocks apart;
  - bytes go out in push order.
- Push while full with a simultaneous pop: hold in_valid=1 while the FIFO is full across a frame boundary -> the push is accepted only in the cycle after the pop, and no byte is lost or duplicated.
- Reset mid-frame: assert rst_n=0 during data bit 3 -> txd=1, busy=0, fifo_count=0 immediately. After release, a push of 0x55 produces one clean frame.
- Divider check: DIV=2 with PARITY=0 -> each bit is held 2 clocks and the frame is 20 clocks.

Source files
------------

// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter with frame-format parameters, a small
// transmit FIFO and a valid/ready push interface. Bit timing comes from an
// internal divider in the system clock domain.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_data    byte to send (only [DATA_BITS-1:0] are transmitted)
//   in_valid   in_data is valid
//   in_ready   FIFO not full; a push happens on in_valid && in_ready
//   txd        serial output, registered, idles high
//   busy       frame on the line or FIFO non-empty
//   fifo_count bytes currently stored in the FIFO
module uart_tx_core #(
    parameter int unsigned DIV        = 868,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = $clog2(DIV);

    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [7:0]    DATA_MASK = 8'((1 << DATA_BITS) - 1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic          txd_q, txd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;

    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic       push;
    logic       pop;
    logic       bit_end;
    logic       fifo_empty;
    logic       data_par;
    logic [7:0] head;

    assign in_ready   = in_ready_q;
    assign txd        = txd_q;
    assign busy       = busy_q;
    assign fifo_count = cnt_q;

    // Next-state, datapath and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        txd_d      = txd_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;

        push       = in_valid && in_ready_q;
        bit_end    = (div_q == DIV_LAST);
        fifo_empty = (wr_q == rd_q);
        head       = fifo_mem[rd_q[AW-1:0]];
        data_par   = ^(head & DATA_MASK);

        // Divider holds 0 in IDLE so every frame starts on a clean bit period
        if (state_q == ST_IDLE) begin
            div_d = '0;
        end else if (bit_end) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    txd_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = 3'd0;
                        if (PARITY != 0) begin
                            state_d = ST_PARITY;
                            txd_d   = par_q;
                        end else begin
                            state_d = ST_STOP;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        txd_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    txd_d     = 1'b1;
                    bit_cnt_d = 3'd0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase

        // Pop loads the head byte and launches a start bit
        if (pop) begin
            state_d = ST_START;
            txd_d   = 1'b0;
            shift_d = head;
            par_d   = (PARITY == 1) ? ~data_par : data_par;
            rd_d    = rd_q + PW'(1);
        end

        if (push) begin
            wr_d = wr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + PW'(1);
            2'b01:   cnt_d = cnt_q - PW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Full when pointers differ only in the wrap bit
        in_ready_d = !((wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]));
        busy_d     = (state_d != ST_IDLE) || (wr_d != rd_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    // FIFO storage; contents are don't-care after reset since pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_q[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench for uart_tx_core across three frame
// formats. Inst 0: DIV=4, 8 data, even parity, 1 stop. Inst 1: DIV=4,
// 7 data, odd parity, 2 stop. Inst 2: DIV=2, 8 data, no parity, 1 stop.
// Expected frames are hand-written bit patterns, bit i = i-th bit on txd.
module tb_uart_tx_core;

    logic       clk;
    logic       rst_n;
    logic [7:0] din    [3];
    logic       vld    [3];
    logic       rdy_w  [3];
    logic       txd_w  [3];
    logic       busy_w [3];
    logic [2:0] cnt_w  [3];

    int checks;
    int errors;
    int cfg_div [3] = '{4, 4, 2};

    logic cap_q [$];
    logic exp_q [$];
    logic cap_on;
    int   cap_idx;

    logic [7:0]  fifo_bytes [6] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h0F, 8'h55};
    logic [11:0] fifo_pats  [6] = '{12'b010000000000, 12'b010111111110,
                                    12'b011000000010, 12'b011100000000,
                                    12'b010000011110, 12'b010010101010};

    uart_tx_core #(.DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(din[0]), .in_valid(vld[0]), .in_ready(rdy_w[0]),
        .txd(txd_w[0]), .busy(busy_w[0]), .fifo_count(cnt_w[0]));

    uart_tx_core #(.DIV(4), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(din[1]), .in_valid(vld[1]), .in_ready(rdy_w[1]),
        .txd(txd_w[1]), .busy(busy_w[1]), .fifo_count(cnt_w[1]));

    uart_tx_core #(.DIV(2), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_data(din[2]), .in_valid(vld[2]), .in_ready(rdy_w[2]),
        .txd(txd_w[2]), .busy(busy_w[2]), .fifo_count(cnt_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and record txd of the captured instance
    task automatic step();
        @(negedge clk);
        if (cap_on) cap_q.push_back(txd_w[cap_idx]);
    endtask

    function automatic void add_frame(logic [11:0] pat, int len, int d);
        for (int i = 0; i < len; i++)
            for (int k = 0; k < d; k++)
                exp_q.push_back(pat[i]);
    endfunction

    task automatic compare_stream(input string tag);
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_s%0d", tag, i), 32'(cap_q[i]), 32'(exp_q[i]));
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_txd%0d", tag, i),  32'(txd_w[i]),  32'd1);
            check($sformatf("%s_rdy%0d", tag, i),  32'(rdy_w[i]),  32'd1);
            check($sformatf("%s_busy%0d", tag, i), 32'(busy_w[i]), 32'd0);
            check($sformatf("%s_cnt%0d", tag, i),  32'(cnt_w[i]),  32'd0);
        end
    endtask

    // Push one byte into an idle instance and check the whole frame on txd
    task automatic send_one(input string tag, input int idx, input logic [7:0] b,
                            input logic [11:0] pat, input int len);
        int total;
        exp_q.delete();
        exp_q.push_back(1'b1);
        add_frame(pat, len, cfg_div[idx]);
        exp_q.push_back(1'b1);
        total = exp_q.size();
        cap_q.delete();
        cap_idx = idx;
        cap_on  = 1'b1;
        din[idx] = b;
        vld[idx] = 1'b1;
        step();
        vld[idx] = 1'b0;
        check({tag, "_cnt_acc"},  32'(cnt_w[idx]),  32'd1);
        check({tag, "_busy_acc"}, 32'(busy_w[idx]), 32'd1);
        step();
        check({tag, "_cnt_start"}, 32'(cnt_w[idx]), 32'd0);
        while (cap_q.size() < total) begin
            step();
            if (cap_q.size() == total - 1)
                check({tag, "_busy_last"}, 32'(busy_w[idx]), 32'd1);
        end
        cap_on = 1'b0;
        check({tag, "_busy_end"}, 32'(busy_w[idx]), 32'd0);
        compare_stream(tag);
    endtask

    initial begin
        int  total;
        int  k;
        bit  sent;
        logic [7:0] c5;

        checks  = 0;
        errors  = 0;
        cap_on  = 1'b0;
        cap_idx = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            vld[i] = 1'b0;
        end

        repeat (3) step();
        check_reset_state("rst_hold");
        rst_n = 1'b1;
        repeat (2) step();
        check_reset_state("rst_rel");

        // Basic frames in each format
        send_one("a5_even", 0, 8'hA5, 12'b010101001010, 11);
        send_one("odd7_2s", 1, 8'h83, 12'b011100000110, 11);
        send_one("div2",    2, 8'h3C, 12'b001001111000, 10);
        repeat (3) step();

        // Fill the FIFO, then hold a sixth push across a frame boundary
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int i = 0; i < 6; i++) add_frame(fifo_pats[i], 11, 4);
        exp_q.push_back(1'b1);
        total = exp_q.size();
        cap_q.delete();
        cap_idx = 0;
        cap_on  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_rdy%0d", i), 32'(rdy_w[0]), 32'd1);
            din[0] = fifo_bytes[i];
            vld[0] = 1'b1;
            step();
            check($sformatf("fill_cnt%0d", i), 32'(cnt_w[0]), (i == 0) ? 32'd1 : 32'(i));
        end
        check("full_rdy", 32'(rdy_w[0]), 32'd0);
        c5   = fifo_bytes[5];
        sent = 1'b0;
        while (cap_q.size() < total) begin
            if (sent) begin
                vld[0] = 1'b0;
            end else if (rdy_w[0]) begin
                din[0] = c5;
                sent   = 1'b1;
            end else begin
                din[0] = 8'($urandom);
            end
            step();
            k = cap_q.size() - 1;
            if (k == 44) begin
                check("pre_pop_cnt", 32'(cnt_w[0]), 32'd4);
                check("pre_pop_rdy", 32'(rdy_w[0]), 32'd0);
            end
            if (k == 45) begin
                check("pop_cnt", 32'(cnt_w[0]), 32'd3);
                check("pop_rdy", 32'(rdy_w[0]), 32'd1);
            end
            if (k == 46) begin
                check("refill_cnt", 32'(cnt_w[0]), 32'd4);
                check("refill_rdy", 32'(rdy_w[0]), 32'd0);
            end
            if (k == total - 2)
                check("fifo_busy_last", 32'(busy_w[0]), 32'd1);
        end
        cap_on = 1'b0;
        check("fifo_busy_end", 32'(busy_w[0]), 32'd0);
        check("fifo_cnt_end",  32'(cnt_w[0]),  32'd0);
        compare_stream("fifo");
        repeat (3) step();

        // Reset during data bit 3 with a second byte queued
        din[0] = 8'h81;
        vld[0] = 1'b1;
        step();
        din[0] = 8'h42;
        step();
        vld[0] = 1'b0;
        check("mid_cnt", 32'(cnt_w[0]), 32'd1);
        repeat (16) step();
        check("mid_busy", 32'(busy_w[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_txd",  32'(txd_w[0]),  32'd1);
        check("arst_busy", 32'(busy_w[0]), 32'd0);
        check("arst_cnt",  32'(cnt_w[0]),  32'd0);
        check("arst_rdy",  32'(rdy_w[0]),  32'd1);
        repeat (2) step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("post_rst_txd%0d", i), 32'(txd_w[0]), 32'd1);
        end
        check("post_rst_busy", 32'(busy_w[0]), 32'd0);
        send_one("after_rst", 0, 8'h55, 12'b010010101010, 11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
